// File: rtl/uart_alu_frame_if_if.sv
// uart_alu_frame_if_if
// Signal bundle between the UART calculator frame block and its surroundings
// (uart_rx, uart_tx, combinational ALU).
//
// Signals:
//   i_rx_done, i_rx_data      received-byte strobe and data
//   i_alu_result              combinational ALU result
//   i_tx_done                 transmitter finished current byte
//   o_operands, o_opcode      registered ALU inputs
//   o_alu_valid               complete-frame strobe
//   o_tx_start, o_tx_data     transmit request and byte
//   o_busy                    frame is executing or its result is being sent
//   o_overrun                 received byte dropped while busy
//   o_frame_error             partial frame discarded on timeout
//
// Modports:
//   master  the frame block (drives o_*)
//   slave   the surroundings (drive i_*)
interface uart_alu_frame_if_if #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned NUM_OPERANDS = 2,
    parameter int unsigned OPCODE_BITS  = 6,
    parameter int unsigned RESULT_BYTES = 1
);
    logic                                 i_rx_done;
    logic [DATA_BITS-1:0]                 i_rx_data;
    logic [RESULT_BYTES*DATA_BITS-1:0]    i_alu_result;
    logic                                 i_tx_done;
    logic [NUM_OPERANDS*DATA_BITS-1:0]    o_operands;
    logic [OPCODE_BITS-1:0]               o_opcode;
    logic                                 o_alu_valid;
    logic                                 o_tx_start;
    logic [DATA_BITS-1:0]                 o_tx_data;
    logic                                 o_busy;
    logic                                 o_overrun;
    logic                                 o_frame_error;

    modport master (
        input  i_rx_done, i_rx_data, i_alu_result, i_tx_done,
        output o_operands, o_opcode, o_alu_valid, o_tx_start, o_tx_data,
        output o_busy, o_overrun, o_frame_error
    );

    modport slave (
        output i_rx_done, i_rx_data, i_alu_result, i_tx_done,
        input  o_operands, o_opcode, o_alu_valid, o_tx_start, o_tx_data,
        input  o_busy, o_overrun, o_frame_error
    );
endinterface

// File: rtl/uart_alu_frame_if.sv
// uart_alu_frame_if
// Assembles a command frame from the UART receive byte stream (NUM_OPERANDS operand
// bytes, then one opcode byte), presents it to a combinational ALU, latches the
// result and sends it LSB byte first to the UART transmitter with a start/done
// handshake. Bytes arriving while busy are dropped and flagged.
//
// Ports:
//   i_clock   system clock
//   i_reset   synchronous, active-high reset
//   bus       uart_alu_frame_if_if.master: rx stream in, operands/opcode/valid out,
//             ALU result in, tx start/data out, tx done in, busy/overrun/frame_error out
//
// Build option FRAME_TIMEOUT_EN: when defined, a partial frame idle for
// TIMEOUT_CYCLES clocks is discarded and o_frame_error pulses. When undefined,
// o_frame_error is tied low and partial frames wait indefinitely.
module uart_alu_frame_if #(
    parameter int unsigned DATA_BITS      = 8,
    parameter int unsigned NUM_OPERANDS   = 2,
    parameter int unsigned OPCODE_BITS    = 6,
    parameter int unsigned RESULT_BYTES   = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input logic                 i_clock,
    input logic                 i_reset,
    uart_alu_frame_if_if.master bus
);
    localparam int unsigned OPS_W      = NUM_OPERANDS * DATA_BITS;
    localparam int unsigned RES_W      = RESULT_BYTES * DATA_BITS;
    localparam int unsigned OP_IDX_W   = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1;
    localparam int unsigned BYTE_IDX_W = (RESULT_BYTES > 1) ? $clog2(RESULT_BYTES) : 1;

    if (NUM_OPERANDS < 1 || RESULT_BYTES < 1 || OPCODE_BITS < 1 ||
        OPCODE_BITS > DATA_BITS || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("uart_alu_frame_if: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        StRxOperand,
        StRxOpcode,
        StExec,
        StTxSend,
        StTxWait
    } state_t;

    state_t                  state_q, state_d;
    logic [OP_IDX_W-1:0]     op_idx_q, op_idx_d;
    logic [BYTE_IDX_W-1:0]   byte_idx_q, byte_idx_d;
    logic [BYTE_IDX_W-1:0]   byte_idx_next;
    logic [OPS_W-1:0]        operands_q, operands_d;
    logic [OPCODE_BITS-1:0]  opcode_q, opcode_d;
    logic [RES_W-1:0]        result_q, result_d;
    logic [DATA_BITS-1:0]    tx_data_q, tx_data_d;
    logic                    alu_valid_q, alu_valid_d;
    logic                    tx_start_q, tx_start_d;
    logic                    busy_q, busy_d;
    logic                    overrun_q, overrun_d;
    logic                    busy_now;

`ifdef FRAME_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);

    logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;
    logic            frame_error_q, frame_error_d;
    logic            partial;
`endif

    assign busy_now      = (state_q == StExec) || (state_q == StTxSend) || (state_q == StTxWait);
    assign byte_idx_next = byte_idx_q + BYTE_IDX_W'(1);

    always_comb begin
        state_d     = state_q;
        op_idx_d    = op_idx_q;
        byte_idx_d  = byte_idx_q;
        operands_d  = operands_q;
        opcode_d    = opcode_q;
        result_d    = result_q;
        tx_data_d   = tx_data_q;

        unique case (state_q)
            StRxOperand: begin
                if (bus.i_rx_done) begin
                    for (int k = 0; k < NUM_OPERANDS; k++) begin
                        if (op_idx_q == OP_IDX_W'(k)) begin
                            operands_d[k*DATA_BITS +: DATA_BITS] = bus.i_rx_data;
                        end
                    end
                    if (op_idx_q == OP_IDX_W'(NUM_OPERANDS - 1)) begin
                        op_idx_d = '0;
                        state_d  = StRxOpcode;
                    end else begin
                        op_idx_d = op_idx_q + OP_IDX_W'(1);
                    end
                end
            end
            StRxOpcode: begin
                if (bus.i_rx_done) begin
                    opcode_d = bus.i_rx_data[OPCODE_BITS-1:0];
                    state_d  = StExec;
                end
            end
            StExec: begin
                // Result register loads this edge, so the first byte comes straight
                // from the ALU rather than from result_q.
                result_d   = bus.i_alu_result;
                tx_data_d  = bus.i_alu_result[DATA_BITS-1:0];
                byte_idx_d = '0;
                state_d    = StTxSend;
            end
            StTxSend: begin
                state_d = StTxWait;
            end
            StTxWait: begin
                if (bus.i_tx_done) begin
                    if (byte_idx_q == BYTE_IDX_W'(RESULT_BYTES - 1)) begin
                        state_d = StRxOperand;
                    end else begin
                        byte_idx_d = byte_idx_next;
                        for (int k = 0; k < RESULT_BYTES; k++) begin
                            if (byte_idx_next == BYTE_IDX_W'(k)) begin
                                tx_data_d = result_q[k*DATA_BITS +: DATA_BITS];
                            end
                        end
                        state_d = StTxSend;
                    end
                end
            end
            default: begin
                state_d = StRxOperand;
            end
        endcase

`ifdef FRAME_TIMEOUT_EN
        idle_cnt_d    = '0;
        frame_error_d = 1'b0;
        partial       = ((state_q == StRxOperand) && (op_idx_q != '0)) || (state_q == StRxOpcode);
        // A byte in the expiry cycle wins over the timeout.
        if (partial && !bus.i_rx_done) begin
            if (idle_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                state_d       = StRxOperand;
                op_idx_d      = '0;
                frame_error_d = 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_q + TO_W'(1);
            end
        end
`endif

        // Registered outputs are derived from the next state.
        overrun_d   = busy_now && bus.i_rx_done;
        alu_valid_d = (state_d == StExec);
        tx_start_d  = (state_d == StTxSend);
        busy_d      = (state_d == StExec) || (state_d == StTxSend) || (state_d == StTxWait);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= StRxOperand;
            op_idx_q    <= '0;
            byte_idx_q  <= '0;
            operands_q  <= '0;
            opcode_q    <= '0;
            result_q    <= '0;
            tx_data_q   <= '0;
            alu_valid_q <= 1'b0;
            tx_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_idx_q    <= op_idx_d;
            byte_idx_q  <= byte_idx_d;
            operands_q  <= operands_d;
            opcode_q    <= opcode_d;
            result_q    <= result_d;
            tx_data_q   <= tx_data_d;
            alu_valid_q <= alu_valid_d;
            tx_start_q  <= tx_start_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef FRAME_TIMEOUT_EN
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            idle_cnt_q    <= '0;
            frame_error_q <= 1'b0;
        end else begin
            idle_cnt_q    <= idle_cnt_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign bus.o_frame_error = frame_error_q;
`else
    assign bus.o_frame_error = 1'b0;
`endif

    assign bus.o_operands  = operands_q;
    assign bus.o_opcode    = opcode_q;
    assign bus.o_alu_valid = alu_valid_q;
    assign bus.o_tx_start  = tx_start_q;
    assign bus.o_tx_data   = tx_data_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_overrun   = overrun_q;
endmodule

// File: tb/tb_uart_alu_frame_if.sv
// tb_uart_alu_frame_if
// Self-checking bench for uart_alu_frame_if: directed frames from the test plan plus
// randomized frames, each compared against a byte-level frame model.
module tb_uart_alu_frame_if;
    localparam int unsigned DATA_BITS      = 8;
    localparam int unsigned NUM_OPERANDS   = 2;
    localparam int unsigned OPCODE_BITS    = 6;
    localparam int unsigned RESULT_BYTES   = 2;
    localparam int unsigned TIMEOUT_CYCLES = 16;
    localparam int unsigned OPS_W          = NUM_OPERANDS * DATA_BITS;
    localparam int unsigned RES_W          = RESULT_BYTES * DATA_BITS;

    logic i_clock = 1'b0;
    logic i_reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    logic             alu_force     = 1'b0;
    logic [RES_W-1:0] alu_force_val = '0;

    // Frame model: operand bytes as last written, opcode, operands taken so far.
    logic [DATA_BITS-1:0]   m_ops [NUM_OPERANDS];
    logic [OPCODE_BITS-1:0] m_opcode;
    int                     m_cnt;

    always #5 i_clock = ~i_clock;

    uart_alu_frame_if_if #(
        .DATA_BITS    (DATA_BITS),
        .NUM_OPERANDS (NUM_OPERANDS),
        .OPCODE_BITS  (OPCODE_BITS),
        .RESULT_BYTES (RESULT_BYTES)
    ) bus ();

    uart_alu_frame_if #(
        .DATA_BITS      (DATA_BITS),
        .NUM_OPERANDS   (NUM_OPERANDS),
        .OPCODE_BITS    (OPCODE_BITS),
        .RESULT_BYTES   (RESULT_BYTES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .bus     (bus)
    );

    // Stand-in ALU: any deterministic mix of operands and opcode will do.
    function automatic logic [RES_W-1:0] alu_ref(input logic [OPS_W-1:0] ops,
                                                 input logic [OPCODE_BITS-1:0] opc);
        int unsigned acc = 7;
        for (int k = 0; k < NUM_OPERANDS; k++) begin
            acc = acc * 131 + 32'(ops[k*DATA_BITS +: DATA_BITS]);
        end
        acc = acc ^ (32'(opc) << 9) ^ 32'(opc);
        return acc[RES_W-1:0];
    endfunction

    assign bus.i_alu_result = alu_force ? alu_force_val : alu_ref(bus.o_operands, bus.o_opcode);

    function automatic logic [OPS_W-1:0] pack_ops();
        logic [OPS_W-1:0] v = '0;
        for (int k = 0; k < NUM_OPERANDS; k++) v[k*DATA_BITS +: DATA_BITS] = m_ops[k];
        return v;
    endfunction

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] pulses();
        return {bus.o_alu_valid, bus.o_tx_start, bus.o_overrun, bus.o_frame_error};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NUM_OPERANDS; k++) m_ops[k] = '0;
        m_opcode = '0;
        m_cnt    = 0;
    endtask

    task automatic push_byte(input logic [DATA_BITS-1:0] b);
        bus.i_rx_data = b;
        bus.i_rx_done = 1'b1;
        tick();
        bus.i_rx_done = 1'b0;
        if (m_cnt < NUM_OPERANDS) begin
            m_ops[m_cnt] = b;
            m_cnt++;
            check_eq("rx_operands", bus.o_operands, pack_ops());
            check_eq("rx_quiet", {pulses(), bus.o_busy}, 5'b0);
        end else begin
            m_opcode = b[OPCODE_BITS-1:0];
            m_cnt    = 0;
            check_eq("exec_valid_busy", {pulses(), bus.o_busy}, 5'b10001);
            check_eq("exec_operands", bus.o_operands, pack_ops());
            check_eq("exec_opcode", bus.o_opcode, m_opcode);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check_eq("idle_pulses", pulses(), 4'b0);
        end
    endtask

    // Called in the EXEC cycle; walks every result byte through the tx handshake.
    task automatic serve_tx(input int max_wait, input bit ovr_mid, input bit ovr_final);
        logic [RES_W-1:0]     exp_res;
        logic [DATA_BITS-1:0] exp_byte;
        int                   n;
        bit                   inject;
        exp_res = alu_force ? alu_force_val : alu_ref(pack_ops(), m_opcode);
        tick();
        for (int i = 0; i < RESULT_BYTES; i++) begin
            exp_byte = exp_res[i*DATA_BITS +: DATA_BITS];
            check_eq("tx_start", {pulses(), bus.o_busy}, 5'b01001);
            check_eq("tx_data", bus.o_tx_data, exp_byte);
            tick();
            check_eq("tx_wait_quiet", {pulses(), bus.o_tx_data}, {4'b0, exp_byte});
            inject = ovr_mid && (i == 0);
            n = $urandom_range(max_wait, inject ? 1 : 0);
            for (int w = 0; w < n; w++) begin
                if (inject && w == 0) begin
                    bus.i_rx_data = 8'h55;
                    bus.i_rx_done = 1'b1;
                end
                tick();
                bus.i_rx_done = 1'b0;
                check_eq("tx_hold", {bus.o_tx_start, bus.o_tx_data, bus.o_busy},
                         {1'b0, exp_byte, 1'b1});
                check_eq("ovr_mid", bus.o_overrun, inject && w == 0);
                if (inject && w == 0) check_eq("ovr_operands", bus.o_operands, pack_ops());
            end
            bus.i_tx_done = 1'b1;
            if (i == RESULT_BYTES - 1 && ovr_final) begin
                bus.i_rx_data = 8'($urandom);
                bus.i_rx_done = 1'b1;
            end
            tick();
            bus.i_tx_done = 1'b0;
            bus.i_rx_done = 1'b0;
            if (i == RESULT_BYTES - 1) begin
                check_eq("tx_end_busy", bus.o_busy, 1'b0);
                check_eq("tx_end_ovr", bus.o_overrun, ovr_final);
            end
        end
    endtask

    task automatic run_frame(input int max_gap, input int max_wait, input bit ovr_mid,
                             input bit ovr_final);
        for (int k = 0; k <= NUM_OPERANDS; k++) begin
            idle($urandom_range(max_gap, 0));
            push_byte(8'($urandom));
        end
        serve_tx(max_wait, ovr_mid, ovr_final);
    endtask

    task automatic directed_beef();
        alu_force     = 1'b1;
        alu_force_val = 16'hBEEF;
        push_byte(8'h12);
        push_byte(8'h34);
        push_byte(8'h20);
        check_eq("beef_operands", bus.o_operands, 16'h3412);
        check_eq("beef_opcode", bus.o_opcode, 6'h20);
        serve_tx(3, 1'b0, 1'b0);
        alu_force = 1'b0;
    endtask

    initial begin
        bus.i_rx_done = 1'b0;
        bus.i_rx_data = '0;
        bus.i_tx_done = 1'b0;
        model_reset();

        tick();
        tick();
        check_eq("reset_state", {bus.o_operands, bus.o_opcode, bus.o_tx_data, pulses(), bus.o_busy},
                 '0);
        i_reset = 1'b0;
        idle(2);

        // Stray tx_done while idle or mid-frame is ignored.
        bus.i_tx_done = 1'b1;
        tick();
        bus.i_tx_done = 1'b0;
        check_eq("stray_txdone_idle", {pulses(), bus.o_busy}, 5'b0);
        directed_beef();
        push_byte(8'h9C);
        bus.i_tx_done = 1'b1;
        tick();
        bus.i_tx_done = 1'b0;
        check_eq("stray_txdone_mid", {pulses(), bus.o_busy}, 5'b0);
        push_byte(8'h3D);
        push_byte(8'hC7);
        check_eq("opcode_low_bits", bus.o_opcode, 6'h07);
        serve_tx(2, 1'b0, 1'b0);

        // Overrun while waiting, then a byte coinciding with the final tx_done.
        run_frame(2, 3, 1'b1, 1'b0);
        run_frame(2, 3, 1'b0, 1'b1);
        run_frame(1, 2, 1'b0, 1'b0);

        // Reset while waiting on the second result byte.
        for (int k = 0; k <= NUM_OPERANDS; k++) push_byte(8'($urandom));
        tick();
        tick();
        bus.i_tx_done = 1'b1;
        tick();
        bus.i_tx_done = 1'b0;
        check_eq("pre_reset_second_start", bus.o_tx_start, 1'b1);
        tick();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        model_reset();
        check_eq("mid_reset_state",
                 {bus.o_operands, bus.o_opcode, bus.o_tx_data, pulses(), bus.o_busy}, '0);
        for (int i = 0; i < 6; i++) begin
            bus.i_tx_done = 1'(i % 2);
            tick();
            check_eq("post_reset_quiet", {pulses(), bus.o_busy}, 5'b0);
        end
        bus.i_tx_done = 1'b0;
        directed_beef();

`ifdef FRAME_TIMEOUT_EN
        // Partial frame times out after TIMEOUT_CYCLES idle clocks.
        push_byte(8'hAA);
        for (int c = 1; c <= TIMEOUT_CYCLES; c++) begin
            tick();
            check_eq("timeout_err", bus.o_frame_error, c == TIMEOUT_CYCLES);
        end
        m_cnt = 0;
        tick();
        check_eq("timeout_err_once", bus.o_frame_error, 1'b0);
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h05);
        check_eq("timeout_next_ops", bus.o_operands, 16'h0201);
        serve_tx(2, 1'b0, 1'b0);

        // A byte in the expiry cycle is accepted and the frame carries on.
        push_byte(8'h11);
        idle(TIMEOUT_CYCLES - 1);
        push_byte(8'h22);
        check_eq("expiry_race_err", bus.o_frame_error, 1'b0);
        push_byte(8'h0F);
        serve_tx(2, 1'b0, 1'b0);
`else
        // Without the timeout a partial frame waits indefinitely.
        push_byte(8'hAA);
        idle(40);
        push_byte(8'hBB);
        push_byte(8'h15);
        check_eq("no_timeout_ops", bus.o_operands, 16'hBBAA);
        serve_tx(2, 1'b0, 1'b0);
`endif

        for (int f = 0; f < 30; f++) begin
            run_frame(3, 4, ($urandom_range(3, 0) == 0), ($urandom_range(3, 0) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/uart_alu_frame_if.md
Name: uart_alu_frame_if

Overview:
Parametrised successor to the UART-to-ALU receive interface. Assembles a command frame from the UART receive byte stream: NUM_OPERANDS operand bytes followed by one opcode byte. It then presents the operands and opcode to the ALU, captures the ALU result, and serialises it byte-by-byte to the UART transmitter using a start/done handshake. It sits between uart_rx/uart_tx and the combinational ALU in the UART calculator top level.

Parameters:
DATA_BITS, 8, width of one UART byte and of each operand
NUM_OPERANDS, 2, operand bytes per frame (>=1)
OPCODE_BITS, 6, opcode width; taken from the low bits of the opcode byte (<=DATA_BITS)
RESULT_BYTES, 1, ALU result width in bytes; all of them are sent per frame (>=1)
TIMEOUT_CYCLES, 1000000, inter-byte timeout in clocks; used only with FRAME_TIMEOUT_EN (>=2)

Ports:
i_clock  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_rx_done  in  1  one-cycle pulse: i_rx_data holds a valid received byte
i_rx_data  in  DATA_BITS  received byte
i_alu_result  in  RESULT_BYTES*DATA_BITS  combinational ALU result
i_tx_done  in  1  one-cycle pulse: the transmitter has finished the current byte
o_operands  out  NUM_OPERANDS*DATA_BITS  operand k occupies bits [k*DATA_BITS +: DATA_BITS]; operand 0 is the first byte received
o_opcode  out  OPCODE_BITS  latched opcode
o_alu_valid  out  1  one-cycle pulse: operands/opcode form a complete frame
o_tx_start  out  1  one-cycle pulse: start transmitting o_tx_data
o_tx_data  out  DATA_BITS  byte to transmit; held stable from o_tx_start until i_tx_done
o_busy  out  1  high in states EXEC, TX_SEND and TX_WAIT
o_overrun  out  1  one-cycle pulse: a byte arrived while busy and was dropped
o_frame_error  out  1  one-cycle pulse: a partial frame was discarded on timeout

Behaviour:
- Reset (synchronous, active-high, i_clock rising edge):
  - All registers and outputs go to 0: operands, opcode, result register, indices, o_tx_data.
  - All pulse outputs are 0; state = RX_OPERAND with op_idx = 0.
  - Reset overrides every other input and aborts any frame or transmission in progress.
- All outputs are registered.
- RX_OPERAND, on i_rx_done:
  - operand[op_idx] <= i_rx_data.
  - If op_idx == NUM_OPERANDS-1: op_idx <= 0 and go to RX_OPCODE; otherwise op_idx++.
- RX_OPCODE, on i_rx_done: opcode <= i_rx_data[OPCODE_BITS-1:0]; go to EXEC.
- EXEC (one cycle):
  - o_alu_valid = 1.
  - Result register <= i_alu_result; the ALU sees stable registered operands/opcode.
  - byte_idx <= 0; go to TX_SEND.
- TX_SEND (one cycle): o_tx_start = 1; o_tx_data = result byte[byte_idx], LSB byte first; go to TX_WAIT.
- TX_WAIT, on i_tx_done:
  - If byte_idx == RESULT_BYTES-1: go to RX_OPERAND.
  - Otherwise byte_idx++ and go to TX_SEND.
- i_tx_done outside TX_WAIT is ignored.
- Latency: o_alu_valid is high the cycle after the opcode byte's i_rx_done. The first o_tx_start follows one cycle later.
- i_rx_done while o_busy = 1:
  - The byte is dropped and o_overrun pulses the next cycle.
  - This includes a coincidence with the final i_tx_done.
- o_operands and o_opcode hold their values after a frame until overwritten by the next frame.
- Partially received operands are not cleared.
- op_idx and byte_idx wrap only through the explicit terminal-count compares above; there are no free-running counters.

Optional Feature:
Macro FRAME_TIMEOUT_EN.
- Defined:
  - An idle counter of width $clog2(TIMEOUT_CYCLES) runs while a frame is partial: state RX_OPERAND with op_idx != 0, or state RX_OPCODE.
  - The counter clears on every i_rx_done.
  - When it reaches TIMEOUT_CYCLES-1: state <= RX_OPERAND, op_idx <= 0, counter <= 0, and o_frame_error pulses the next cycle.
  - i_rx_done in the same cycle as expiry wins: the byte is taken normally and no error is raised.
  - The counter is held at 0 in every other state.
- Not defined: no counter logic; o_frame_error is tied to 0; partial frames wait indefinitely.

Test Plan:
- Defaults, RESULT_BYTES=2: bytes 0x12, 0x34, 0x20 with ALU result 0xBEEF -> o_operands=0x3412, o_opcode=0x20, one o_alu_valid pulse; then o_tx_start with 0xEF, i_tx_done, o_tx_start with 0xBE, i_tx_done -> back to idle with o_busy=0.
- NUM_OPERANDS=3: bytes 0x01, 0x02, 0x03, 0xFF -> o_operands=0x030201, o_opcode=0x3F (low 6 bits); o_alu_valid exactly one cycle after the 4th i_rx_done.
- Byte 0x55 sent while in TX_WAIT -> o_overrun pulses once; o_operands unchanged; next frame assembles correctly from operand 0.
- i_reset asserted during TX_WAIT after the first of 2 bytes -> no further o_tx_start; all outputs 0; a following full frame behaves as in the first test.
- FRAME_TIMEOUT_EN, TIMEOUT_CYCLES=16: one byte 0xAA then 16 idle cycles -> o_frame_error pulses once; next bytes 0x01, 0x02, 0x05 -> o_operands=0x0201.
- FRAME_TIMEOUT_EN: second byte arrives exactly in the expiry cycle -> accepted, no o_frame_error, state RX_OPCODE.
